// File: rtl/rv32_pipeline_ctrl_if.sv
// Event and control bundle between the rv32 pipeline stages and the stall/flush sequencer.
// The master side (the stages) raises hazard events; the slave side (the sequencer) returns stop/flush controls.
interface rv32_pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             do_jump;
  logic             load_use;
  logic             muldiv_start;
  logic             muldiv_done;
  logic             mem_busy;
  logic             stop_if;
  logic             stop_id;
  logic             stop_ex;
  logic             flush_if;
  logic             flush_id;
  logic             bubble_ex;
  logic             muldiv_abort;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output do_jump, load_use, muldiv_start, muldiv_done, mem_busy,
    input  stop_if, stop_id, stop_ex, flush_if, flush_id, bubble_ex,
           muldiv_abort, timeout_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  do_jump, load_use, muldiv_start, muldiv_done, mem_busy,
    output stop_if, stop_id, stop_ex, flush_if, flush_id, bubble_ex,
           muldiv_abort, timeout_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/rv32_pipeline_ctrl.sv
// Stall/flush sequencer for the rv32 five-stage pipeline: post-jump flush window,
// mul/div wait with timeout, and saturating stall/flush performance counters.
module rv32_pipeline_ctrl #(
  parameter int FLUSH_CYCLES  = 2,
  parameter int MULTI_TIMEOUT = 64,
  parameter int CNT_W         = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  rv32_pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, FLUSH, MULTI} state_e;

  localparam logic [2:0] FLOAD = 3'(FLUSH_CYCLES - 1);
  // tcnt counts the start cycle as 1, so the abort cycle is the one entered with tcnt = MULTI_TIMEOUT-1
  localparam logic [7:0] TLAST = 8'(MULTI_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic             terr_q;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic stop_c, stop_fd_c, flush_c, bubble_c, abort_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    tcnt_d    = tcnt_q;
    stop_c    = 1'b0;
    stop_fd_c = 1'b0;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;
    abort_c   = 1'b0;
    if (bus.mem_busy) begin
      stop_c    = 1'b1;
      stop_fd_c = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.do_jump) begin
            flush_c = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              fcnt_d  = FLOAD;
            end
          end else if (bus.muldiv_start) begin
            stop_c    = 1'b1;
            stop_fd_c = 1'b1;
            tcnt_d    = 8'd1;
            state_d   = MULTI;
          end else if (bus.load_use) begin
            stop_fd_c = 1'b1;
            bubble_c  = 1'b1;
          end
        end
        FLUSH: begin
          flush_c = 1'b1;
          if (fcnt_q == 3'd1) begin
            state_d = RUN;
            fcnt_d  = 3'd0;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
        MULTI: begin
          if (bus.muldiv_done) begin
            state_d = RUN;
            tcnt_d  = 8'd0;
          end else if (tcnt_q == TLAST) begin
            abort_c = 1'b1;
            state_d = RUN;
            tcnt_d  = 8'd0;
          end else begin
            stop_c    = 1'b1;
            stop_fd_c = 1'b1;
            tcnt_d    = tcnt_q + 8'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
      tcnt_q  <= 8'd0;
      terr_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      tcnt_q  <= tcnt_d;
      terr_q  <= terr_q | abort_c;
      if (stop_fd_c) stall_q <= sat_inc(stall_q);
      if (flush_c)   flush_q <= sat_inc(flush_q);
    end
  end

  // Combinational outputs are forced low while reset is held, independent of inputs
  assign bus.stop_if      = stop_fd_c & resetn;
  assign bus.stop_id      = stop_fd_c & resetn;
  assign bus.stop_ex      = stop_c & resetn;
  assign bus.flush_if     = flush_c & resetn;
  assign bus.flush_id     = flush_c & resetn;
  assign bus.bubble_ex    = bubble_c & resetn;
  assign bus.muldiv_abort = abort_c & resetn;
  assign bus.timeout_err  = terr_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;

endmodule

// File: tb/tb_rv32_pipeline_ctrl.sv
// Bench for rv32_pipeline_ctrl: directed vector table, hand-written multi-cycle sequences,
// then random traffic checked against a cycle-count reference model.
module tb_rv32_pipeline_ctrl;

  localparam int FC   = 2;
  localparam int MT   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [4:0] J  = 5'b10000;
  localparam logic [4:0] LU = 5'b01000;
  localparam logic [4:0] ST = 5'b00100;
  localparam logic [4:0] DN = 5'b00010;
  localparam logic [4:0] MB = 5'b00001;

  typedef struct {
    logic [4:0] in;
    logic [7:0] exp;
    int         stall;
    int         flush;
  } vec_t;

  logic clk;
  logic resetn;
  int   nvec;
  int   nerr;

  int   m_flush_left;
  int   m_multi_age;
  int   m_stall;
  int   m_flush;
  logic m_terr;

  vec_t tbl[18];

  rv32_pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  rv32_pipeline_ctrl #(
    .FLUSH_CYCLES (FC),
    .MULTI_TIMEOUT(MT),
    .CNT_W        (CW)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] dut_outs();
    return {bus.stop_if, bus.stop_id, bus.stop_ex, bus.flush_if, bus.flush_id,
            bus.bubble_ex, bus.muldiv_abort, bus.timeout_err};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] in);
    bus.do_jump      = in[4];
    bus.load_use     = in[3];
    bus.muldiv_start = in[2];
    bus.muldiv_done  = in[1];
    bus.mem_busy     = in[0];
  endtask

  // Reference: remaining flush cycles and the index of the current cycle of a mul/div wait
  function automatic logic [7:0] model_outs(input logic [4:0] in);
    logic [7:0] r;
    r = {7'b0, m_terr};
    if (in[0])                return 8'hE0 | r;
    if (m_flush_left > 0)     return 8'h18 | r;
    if (m_multi_age > 0) begin
      if (in[1])              return r;
      if (m_multi_age == MT)  return 8'h02 | r;
      return 8'hE0 | r;
    end
    if (in[4])                return 8'h18 | r;
    if (in[2])                return 8'hE0 | r;
    if (in[3])                return 8'hC4 | r;
    return r;
  endfunction

  task automatic model_step(input logic [4:0] in);
    logic [7:0] o;
    o = model_outs(in);
    if (o[7] && m_stall < CMAX) m_stall++;
    if (o[4] && m_flush < CMAX) m_flush++;
    if (o[1]) m_terr = 1'b1;
    if (!in[0]) begin
      if (m_flush_left > 0) m_flush_left--;
      else if (m_multi_age > 0) begin
        if (in[1] || m_multi_age == MT) m_multi_age = 0;
        else m_multi_age++;
      end
      else if (in[4]) m_flush_left = FC - 1;
      else if (in[2]) m_multi_age = 2;
    end
  endtask

  task automatic model_reset();
    m_flush_left = 0;
    m_multi_age  = 0;
    m_stall      = 0;
    m_flush      = 0;
    m_terr       = 1'b0;
  endtask

  task automatic do_reset();
    drive(5'b0);
    resetn = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic step_model(input logic [4:0] in, input string name);
    drive(in);
    #2;
    check({name, "_outs"},  dut_outs(),         model_outs(in));
    check({name, "_stall"}, int'(bus.stall_cnt), m_stall);
    check({name, "_flush"}, int'(bus.flush_cnt), m_flush);
    model_step(in);
    @(posedge clk);
    #1;
  endtask

  task automatic step_hand(input logic [4:0] in, input logic [7:0] exp, input string name);
    drive(in);
    #2;
    check(name, dut_outs(), exp);
    model_step(in);
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    drive(5'b0);
    resetn = 1'b0;
    model_reset();

    tbl[0]  = '{5'b0,        8'h00, 0, 0};
    tbl[1]  = '{5'b0,        8'h00, 0, 0};
    tbl[2]  = '{5'b0,        8'h00, 0, 0};
    tbl[3]  = '{J,           8'h18, 0, 0};
    tbl[4]  = '{J,           8'h18, 0, 1};
    tbl[5]  = '{5'b0,        8'h00, 0, 2};
    tbl[6]  = '{LU,          8'hC4, 0, 2};
    tbl[7]  = '{5'b0,        8'h00, 1, 2};
    tbl[8]  = '{J | ST | LU, 8'h18, 1, 2};
    tbl[9]  = '{5'b0,        8'h18, 1, 3};
    tbl[10] = '{5'b0,        8'h00, 1, 4};
    tbl[11] = '{ST,          8'hE0, 1, 4};
    tbl[12] = '{5'b0,        8'hE0, 2, 4};
    tbl[13] = '{LU | J,      8'hE0, 3, 4};
    tbl[14] = '{DN,          8'h00, 4, 4};
    tbl[15] = '{5'b0,        8'h00, 4, 4};
    tbl[16] = '{MB,          8'hE0, 4, 4};
    tbl[17] = '{DN,          8'h00, 5, 4};

    // Held in reset: everything low even with inputs active
    #3;
    drive(J | ST | MB);
    #1;
    check("in_reset_outs", dut_outs(), 8'h00);
    do_reset();

    for (int i = 0; i < 10; i++) step_model(5'b0, "idle");

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].in);
      #2;
      check($sformatf("tbl%0d_outs", i),  dut_outs(),          tbl[i].exp);
      check($sformatf("tbl%0d_stall", i), int'(bus.stall_cnt), tbl[i].stall);
      check($sformatf("tbl%0d_flush", i), int'(bus.flush_cnt), tbl[i].flush);
      model_step(tbl[i].in);
      @(posedge clk);
      #1;
    end

    // Mul/div timeout: abort on the 8th cycle counting the start cycle as the first
    do_reset();
    for (int c = 0; c < 10; c++)
      step_hand((c == 0) ? ST : 5'b0,
                (c < 7) ? 8'hE0 : (c == 7) ? 8'h02 : 8'h01,
                $sformatf("timeout_c%0d", c));
    check("timeout_stall", int'(bus.stall_cnt), 7);

    // Reset dropped in the middle of a mul/div wait
    step_hand(ST, 8'hE1, "rstmid_start");
    step_hand(5'b0, 8'hE1, "rstmid_wait");
    drive(MB);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check("rstmid_outs",  dut_outs(),          8'h00);
    check("rstmid_stall", int'(bus.stall_cnt), 0);
    check("rstmid_flush", int'(bus.flush_cnt), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive(5'b0);
    @(posedge clk);
    #1;
    step_hand(5'b0, 8'h00, "rstmid_resume");

    // mem_busy for three cycles inside the jump window
    do_reset();
    step_hand(J,    8'h18, "busyfl_c0");
    step_hand(MB,   8'hE0, "busyfl_c1");
    step_hand(MB | J, 8'hE0, "busyfl_c2");
    step_hand(MB,   8'hE0, "busyfl_c3");
    step_hand(5'b0, 8'h18, "busyfl_c4");
    step_hand(5'b0, 8'h00, "busyfl_c5");
    check("busyfl_flush", int'(bus.flush_cnt), FC);
    check("busyfl_stall", int'(bus.stall_cnt), 3);

    // Random traffic against the reference model; small counters reach saturation
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] in;
      in[4] = ($urandom_range(99) < 8);
      in[3] = ($urandom_range(99) < 15);
      in[2] = ($urandom_range(99) < 10);
      in[1] = ($urandom_range(99) < 12);
      in[0] = ($urandom_range(99) < 10);
      step_model(in, "rand");
      if (i == 1500) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
